addsub_pipe: RTL

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pipe_if.sv | 32 +++
 rtl/addsub_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result bundle for addsub_pipe.
//   in_valid/in_ready  : operand handshake (a, b, cin, op)
//   out_valid/out_ready: result handshake (sum, cout, ovf, zero, shiftedcarry)
//   op encoding        : 00 ADD, 01 SUB, 10 INC, 11 PASS
// master drives operands and out_ready; slave (the adder) drives the rest.
interface addsub_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [WIDTH:0]   shiftedcarry;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, shiftedcarry
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, shiftedcarry
  );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined ripple adder/subtractor, SLICE bits per stage.
//   clk, rst_n : single rising-edge clock, asynchronous active-low reset
//   bus        : addsub_pipe_if slave port
//                operands a/b/cin/op accepted on in_valid && in_ready;
//                result sum/cout/ovf/zero/shiftedcarry presented with
//                out_valid, consumed on out_ready.
// Latency is NSTAGE = WIDTH/SLICE cycles; one operand set per cycle.
// The whole pipeline advances together whenever the output register is
// empty or being consumed (in_ready = !out_valid || out_ready).
module addsub_pipe #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_pipe_if.slave bus
);

  localparam int NSTAGE = WIDTH / SLICE;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_INC  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  logic             adv;
  logic [WIDTH-1:0] eff_a;
  logic [WIDTH-1:0] eff_b;
  logic             eff_c;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  // Operand conditioning: every op reduces to A + B + C.
  always_comb begin
    eff_a = bus.a;
    eff_b = bus.b;
    eff_c = bus.cin;
    case (op_e'(bus.op))
      OP_ADD:  ;
      OP_SUB:  eff_b = ~bus.b;
      OP_INC:  begin
        eff_b = '0;
        eff_c = 1'b1;
      end
      OP_PASS: begin
        eff_b = '0;
        eff_c = 1'b0;
      end
      default: ;
    endcase
  end

  // Stage k adds bits [LO +: SLICE]. Its input carries only what it still
  // needs: operand bits from LO upward (skew) and the completed sum and
  // carry bits below LO (deskew), so every register is exactly sized and
  // the last stage holds a full, self-consistent result.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int LO = k * SLICE;
    localparam int HI = LO + SLICE;

    logic [WIDTH-1:LO] a_in;
    logic [WIDTH-1:LO] b_in;
    logic [LO:0]       c_in;     // c_in[LO] is the carry into this slice
    logic              v_in;
    logic [SLICE-1:0]  s_slice;
    logic [SLICE:0]    c_slice;
    logic [HI-1:0]     sum_nx;
    logic [HI:0]       sc_nx;

    logic              v_q, v_d;
    logic [HI-1:0]     sum_q, sum_d;
    logic [HI:0]       sc_q, sc_d;

    if (k == 0) begin : g_head
      assign a_in   = eff_a;
      assign b_in   = eff_b;
      assign c_in   = eff_c;
      assign v_in   = bus.in_valid;
      assign sum_nx = s_slice;
    end else begin : g_body
      assign a_in   = g_stage[k-1].g_skew.a_q;
      assign b_in   = g_stage[k-1].g_skew.b_q;
      assign c_in   = g_stage[k-1].sc_q;
      assign v_in   = g_stage[k-1].v_q;
      assign sum_nx = {s_slice, g_stage[k-1].sum_q};
    end

    assign sc_nx = {c_slice[SLICE:1], c_in};

    always_comb begin
      s_slice    = '0;
      c_slice    = '0;
      c_slice[0] = c_in[LO];
      for (int unsigned j = 0; j < SLICE; j++) begin
        s_slice[j]   = a_in[LO+j] ^ b_in[LO+j] ^ c_slice[j];
        c_slice[j+1] = (a_in[LO+j] & b_in[LO+j]) |
                       (c_slice[j] & (a_in[LO+j] ^ b_in[LO+j]));
      end
    end

    always_comb begin
      v_d   = v_q;
      sum_d = sum_q;
      sc_d  = sc_q;
      if (adv) begin
        v_d   = v_in;
        sum_d = sum_nx;
        sc_d  = sc_nx;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        sc_q  <= '0;
      end else begin
        v_q   <= v_d;
        sum_q <= sum_d;
        sc_q  <= sc_d;
      end
    end

    // Operand bits not yet consumed travel alongside the partial result.
    if (k < NSTAGE - 1) begin : g_skew
      logic [WIDTH-1:HI] a_q, a_d;
      logic [WIDTH-1:HI] b_q, b_d;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = a_in[WIDTH-1:HI];
          b_d = b_in[WIDTH-1:HI];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign adv = !g_stage[NSTAGE-1].v_q || bus.out_ready;

  // zero and ovf are derived from the final stage's next value so the
  // outputs stay purely registered.
  always_comb begin
    zero_d = zero_q;
    ovf_d  = ovf_q;
    if (adv) begin
      zero_d = (g_stage[NSTAGE-1].sum_nx == '0);
      ovf_d  = g_stage[NSTAGE-1].sc_nx[WIDTH] ^ g_stage[NSTAGE-1].sc_nx[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.in_ready     = adv;
  assign bus.out_valid    = g_stage[NSTAGE-1].v_q;
  assign bus.sum          = g_stage[NSTAGE-1].sum_q;
  assign bus.shiftedcarry = g_stage[NSTAGE-1].sc_q;
  assign bus.cout         = g_stage[NSTAGE-1].sc_q[WIDTH];
  assign bus.ovf          = ovf_q;
  assign bus.zero         = zero_q;

endmodule
